// File: rtl/apb_master_mc_if.sv
// Request/response port plus multi-slave APB bus for apb_master_mc.
// The master modport is the controller's view; the slave modport is the view of the source and fabric.
interface apb_master_mc_if #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2
) ();
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [ADDR_W-1:0]         req_addr;
    logic [DATA_W-1:0]         req_wdata;
    logic                      rsp_valid;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;
    logic [NUM_SLV-1:0]        psel;
    logic                      penable;
    logic                      pwrite;
    logic [ADDR_W-1:0]         paddr;
    logic [DATA_W-1:0]         pwdata;
    logic [NUM_SLV*DATA_W-1:0] prdata;
    logic [NUM_SLV-1:0]        pready;
    logic [NUM_SLV-1:0]        pslverr;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, prdata, pready, pslverr,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master_mc.sv
// Multi-slave APB master: valid/ready requests become SETUP/ACCESS transfers with
// address-based slave decode, wait-state timeout and a one-cycle response pulse.
module apb_master_mc #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int NUM_SLV = 2,
    parameter int TIMEOUT = 16
) (
    input  logic            pclk,
    input  logic            presetn,
    apb_master_mc_if.master bus
);
    localparam int SEL_W  = $clog2(NUM_SLV);
    localparam int SEL_IW = (SEL_W > 0) ? SEL_W : 1;
    localparam int CNT_W  = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t              state_q, state_d;
    logic [SEL_IW-1:0]   cur_q, cur_d, idx;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                pend_q, pend_d;
    logic [NUM_SLV-1:0]  psel_q, psel_d;
    logic                penable_q, penable_d;
    logic                pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]   paddr_q, paddr_d;
    logic [DATA_W-1:0]   pwdata_q, pwdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
    logic                rsp_err_q, rsp_err_d;

    logic                dec_err, cur_rdy, cur_err, timeout_hit, done, req_ready, accept;
    logic [DATA_W-1:0]   cur_rdata;

    generate
        if (NUM_SLV > 1) begin : g_dec
            assign idx = bus.req_addr[ADDR_W-1 -: SEL_W];
        end else begin : g_one
            assign idx = '0;
        end
    endgenerate

    assign dec_err     = (int'(idx) >= NUM_SLV);
    assign cur_rdy     = bus.pready[cur_q];
    assign cur_err     = bus.pslverr[cur_q];
    assign cur_rdata   = bus.prdata[int'(cur_q)*DATA_W +: DATA_W];
    assign timeout_hit = (TIMEOUT != 0) && (state_q == ACCESS) && !cur_rdy &&
                         (cnt_q == CNT_W'(TIMEOUT - 1));
    assign done        = (state_q == ACCESS) && (cur_rdy || timeout_hit);
    assign req_ready   = (state_q == IDLE) || done;
    assign accept      = bus.req_valid && req_ready;

    always_comb begin
        state_d     = state_q;
        cur_d       = cur_q;
        cnt_d       = cnt_q;
        pend_d      = 1'b0;
        psel_d      = psel_q;
        penable_d   = penable_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = pend_q;
        rsp_err_d   = pend_q;
        rsp_rdata_d = '0;

        case (state_q)
            SETUP: begin
                state_d   = ACCESS;
                penable_d = 1'b1;
            end
            ACCESS: begin
                if (!cur_rdy) cnt_d = cnt_q + CNT_W'(1);
                if (done) begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = cur_rdy ? cur_err : 1'b1;
                    rsp_rdata_d = (cur_rdy && !cur_err && !pwrite_q) ? cur_rdata : '0;
                    state_d     = IDLE;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                end
            end
            default: ;
        endcase

        if (accept) begin
            cur_d    = idx;
            pwrite_d = bus.req_write;
            paddr_d  = bus.req_addr;
            pwdata_d = bus.req_wdata;
            if (dec_err) begin
                // Response slot already taken by a completion: emit the decode error one cycle later.
                if (rsp_valid_d) begin
                    pend_d = 1'b1;
                end else begin
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end
                state_d = IDLE;
            end else begin
                state_d   = SETUP;
                psel_d    = NUM_SLV'(1) << idx;
                penable_d = 1'b0;
                cnt_d     = '0;
            end
        end
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            state_q     <= IDLE;
            cur_q       <= '0;
            cnt_q       <= '0;
            pend_q      <= 1'b0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cur_q       <= cur_d;
            cnt_q       <= cnt_d;
            pend_q      <= pend_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.req_ready = req_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
endmodule

// File: tb/tb_apb_master_mc.sv
// Bench for apb_master_mc: a default two-slave instance under random and directed traffic
// against a transaction-level model, plus a three-slave TIMEOUT=4 instance for abort/decode cases.
module tb_apb_master_mc;
    localparam int TIMEOUT_A = 16;

    logic pclk;
    logic presetn;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    int   last_acc = 0;
    int   phase = 0;

    typedef struct {
        logic       write;
        logic [7:0] addr;
        logic [7:0] wdata;
        int         slave;
        int         wt;
        logic       err;
        logic [7:0] rdata;
        logic       exp_err;
        logic [7:0] exp_rdata;
        int         done;
    } txn_t;

    txn_t exp_q[$];

    apb_master_mc_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(2)) ia ();
    apb_master_mc_if #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3)) ib ();

    apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(2), .TIMEOUT(TIMEOUT_A)) dut_a (
        .pclk(pclk), .presetn(presetn), .bus(ia));
    apb_master_mc #(.ADDR_W(8), .DATA_W(8), .NUM_SLV(3), .TIMEOUT(4)) dut_b (
        .pclk(pclk), .presetn(presetn), .bus(ib));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    function automatic void chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endfunction

    // Slave fabric for instance A plus response/bus monitor, driven on the falling edge.
    always @(negedge pclk) begin
        logic [1:0]  rdy;
        logic [1:0]  serr;
        logic [15:0] rdat;
        txn_t        t;
        rdy  = 2'($urandom);
        serr = 2'($urandom);
        rdat = 16'($urandom);
        if (!presetn) begin
            phase = 0;
        end else begin
            if (ia.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk("a_rsp_spurious", 1, 0);
                end else begin
                    t = exp_q.pop_front();
                    chk("a_rsp_cycle", cyc, t.done);
                    chk("a_rsp_err", ia.rsp_err, t.exp_err);
                    chk("a_rsp_rdata", ia.rsp_rdata, t.exp_rdata);
                    phase = 0;
                end
            end
            if (ia.psel != 2'b00) begin
                if (exp_q.size() == 0) begin
                    chk("a_psel_spurious", ia.psel, 0);
                end else begin
                    t = exp_q[0];
                    chk("a_psel", ia.psel, (t.slave == 1) ? 2'b10 : 2'b01);
                    chk("a_paddr", ia.paddr, t.addr);
                    chk("a_pwrite", ia.pwrite, t.write);
                    chk("a_pwdata", ia.pwdata, t.wdata);
                    chk("a_penable", ia.penable, (phase > 0));
                    if (ia.penable && (phase - 1 == t.wt)) begin
                        rdy[t.slave]  = 1'b1;
                        serr[t.slave] = t.err;
                        rdat[t.slave*8 +: 8] = t.rdata;
                    end else begin
                        rdy[t.slave] = 1'b0;
                    end
                    phase++;
                end
            end
        end
        ia.pready  = rdy;
        ia.pslverr = serr;
        ia.prdata  = rdat;
    end

    task automatic xfer(input logic w, input logic [7:0] a, input logic [7:0] d, input int wt,
                        input logic e, input logic [7:0] rd, input int gap);
        txn_t t;
        int   n;
        logic to;
        if (gap > 0) begin
            ia.req_valid = 1'b0;
            repeat (gap) @(negedge pclk);
        end
        ia.req_valid = 1'b1;
        ia.req_write = w;
        ia.req_addr  = a;
        ia.req_wdata = d;
        n = 0;
        #2;
        while (!ia.req_ready && n < 64) begin
            @(negedge pclk);
            #2;
            n++;
        end
        if (!ia.req_ready) begin
            chk("a_req_ready_wait", 0, 1);
            ia.req_valid = 1'b0;
            return;
        end
        to          = (wt >= TIMEOUT_A);
        t.write     = w;
        t.addr      = a;
        t.wdata     = d;
        t.slave     = int'(a[7]);
        t.wt        = wt;
        t.err       = e;
        t.rdata     = rd;
        t.exp_err   = to ? 1'b1 : e;
        t.exp_rdata = (!to && !e && !w) ? rd : 8'h00;
        t.done      = cyc + 1 + (to ? 1 + TIMEOUT_A : 2 + wt);
        last_acc    = cyc + 1;
        exp_q.push_back(t);
        @(negedge pclk);
        ia.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge pclk);
            n++;
        end
        chk("a_drain", exp_q.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int a1;
        presetn      = 1'b0;
        ia.req_valid = 1'b0;
        ia.req_write = 1'b0;
        ia.req_addr  = 8'h00;
        ia.req_wdata = 8'h00;
        ib.req_valid = 1'b0;
        ib.req_write = 1'b0;
        ib.req_addr  = 8'h00;
        ib.req_wdata = 8'h00;
        ib.pready    = 3'b000;
        ib.pslverr   = 3'b000;
        ib.prdata    = 24'h000000;

        #12;
        chk("rst_a_psel", ia.psel, 0);
        chk("rst_a_penable", ia.penable, 0);
        chk("rst_a_rsp_valid", ia.rsp_valid, 0);
        chk("rst_a_paddr", ia.paddr, 0);
        chk("rst_a_req_ready", ia.req_ready, 1);
        chk("rst_b_psel", ib.psel, 0);
        @(negedge pclk);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);

        // Zero-wait write, read with wait states, back-to-back with slave error.
        xfer(1'b1, 8'h85, 8'h3C, 0, 1'b0, 8'h00, 1);
        drain();
        xfer(1'b0, 8'h12, 8'h00, 3, 1'b0, 8'hA5, 1);
        drain();
        xfer(1'b1, 8'h10, 8'h4B, 0, 1'b0, 8'h00, 1);
        a1 = last_acc;
        xfer(1'b0, 8'h90, 8'h00, 0, 1'b1, 8'h5A, 0);
        chk("a_b2b_spacing", last_acc - a1, 2);
        drain();

        for (int i = 0; i < 150; i++) begin
            int r;
            r = int'($urandom_range(0, 7));
            xfer(1'($urandom), 8'($urandom), 8'($urandom), (r == 7) ? 17 : (r % 4),
                 ($urandom_range(0, 3) == 0), 8'($urandom), int'($urandom_range(0, 2)));
        end
        drain();

        // Reset in the middle of a long ACCESS phase.
        xfer(1'b1, 8'h47, 8'hD2, 30, 1'b0, 8'h00, 1);
        repeat (3) @(negedge pclk);
        #3;
        presetn = 1'b0;
        exp_q.delete();
        #1;
        chk("arst_psel", ia.psel, 0);
        chk("arst_penable", ia.penable, 0);
        chk("arst_pwrite", ia.pwrite, 0);
        chk("arst_paddr", ia.paddr, 0);
        chk("arst_pwdata", ia.pwdata, 0);
        chk("arst_rsp_valid", ia.rsp_valid, 0);
        repeat (2) @(negedge pclk);
        chk("arst_rsp_hold", ia.rsp_valid, 0);
        presetn = 1'b1;
        @(negedge pclk);
        xfer(1'b0, 8'h01, 8'h00, 1, 1'b0, 8'h6E, 1);
        drain();

        // Instance B: timeout after 4 ACCESS cycles, then a normal transfer.
        @(negedge pclk);
        ib.req_valid = 1'b1;
        ib.req_write = 1'b0;
        ib.req_addr  = 8'h20;
        ib.prdata    = 24'hFFFFFF;
        #2;
        chk("b_ready_idle", ib.req_ready, 1);
        @(negedge pclk);
        ib.req_valid = 1'b0;
        chk("b_setup_psel", ib.psel, 3'b001);
        chk("b_setup_penable", ib.penable, 0);
        for (int k = 0; k < 4; k++) begin
            @(negedge pclk);
            chk("b_acc_psel", ib.psel, 3'b001);
            chk("b_acc_penable", ib.penable, 1);
            chk("b_acc_rsp_valid", ib.rsp_valid, 0);
            #2;
            chk("b_acc_req_ready", ib.req_ready, (k == 3));
        end
        @(negedge pclk);
        chk("b_to_psel", ib.psel, 0);
        chk("b_to_penable", ib.penable, 0);
        chk("b_to_rsp_valid", ib.rsp_valid, 1);
        chk("b_to_rsp_err", ib.rsp_err, 1);
        chk("b_to_rsp_rdata", ib.rsp_rdata, 0);
        ib.req_valid = 1'b1;
        ib.req_write = 1'b1;
        ib.req_addr  = 8'h41;
        ib.req_wdata = 8'h99;
        ib.pready    = 3'b010;
        #2;
        chk("b_next_ready", ib.req_ready, 1);
        @(negedge pclk);
        ib.req_valid = 1'b0;
        chk("b_next_psel", ib.psel, 3'b010);
        chk("b_next_paddr", ib.paddr, 8'h41);
        chk("b_next_pwdata", ib.pwdata, 8'h99);
        chk("b_next_pwrite", ib.pwrite, 1);
        @(negedge pclk);
        chk("b_next_penable", ib.penable, 1);
        @(negedge pclk);
        chk("b_next_rsp_valid", ib.rsp_valid, 1);
        chk("b_next_rsp_err", ib.rsp_err, 0);

        // Instance B: decode error on slave index 3.
        @(negedge pclk);
        ib.req_valid = 1'b1;
        ib.req_write = 1'b0;
        ib.req_addr  = 8'hC0;
        #2;
        chk("b_dec_ready", ib.req_ready, 1);
        @(negedge pclk);
        ib.req_valid = 1'b0;
        chk("b_dec_psel", ib.psel, 0);
        chk("b_dec_rsp_valid", ib.rsp_valid, 1);
        chk("b_dec_rsp_err", ib.rsp_err, 1);
        chk("b_dec_rsp_rdata", ib.rsp_rdata, 0);
        @(negedge pclk);
        chk("b_dec_rsp_once", ib.rsp_valid, 0);
        chk("b_dec_psel_after", ib.psel, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
